// File: rtl/output_packer_pkg.sv
// Shared constants and types for the output packer and its unpack counterparts.
// Purpose: derives element/beat counts and counter widths from the packer
// parameters, and provides the per-beat element array type used by the
// pack/unpack drivers at the default configuration.
package output_packer_pkg;

  localparam int unsigned DEF_IO_DATA_WIDTH = 8;
  localparam int unsigned DEF_MEM_BW        = 128;
  localparam int unsigned DEF_IN_LANES      = 4;

  // One beat of elements, lane 0 first.
  typedef logic [DEF_IO_DATA_WIDTH-1:0] elem_arr_t [DEF_IN_LANES];

  // Elements per memory word.
  function automatic int unsigned calc_elems(input int unsigned mem_bw,
                                             input int unsigned io_w);
    return mem_bw / io_w;
  endfunction

  // Input beats per memory word.
  function automatic int unsigned calc_beats(input int unsigned mem_bw,
                                             input int unsigned io_w,
                                             input int unsigned lanes);
    return (mem_bw / io_w) / lanes;
  endfunction

  // Beat counter width; at least one bit so a single-beat word still works.
  function automatic int unsigned calc_bcnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Element count width, wide enough to hold the full value ELEMS.
  function automatic int unsigned calc_cnt_w(input int unsigned elems);
    return $clog2(elems) + 1;
  endfunction

endpackage

// File: rtl/packer_lane_insert.sv
// Combinational lane merge.
// Purpose: writes IN_LANES elements into a MEM_BW word at beat offset beat_in;
// element k = beat_in*IN_LANES + lane lands at [MEM_BW-1-k*IO_DATA_WIDTH -: IO_DATA_WIDTH]
// so element 0 sits at the MSB end. All other bits pass through from word_in.
// Ports:
//   word_in   current word contents
//   lanes_in  elements of this beat, lane 0 first
//   beat_in   beat offset within the word
//   word_c    merged word
module packer_lane_insert
  import output_packer_pkg::*;
#(
  parameter  int unsigned IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter  int unsigned MEM_BW        = DEF_MEM_BW,
  parameter  int unsigned IN_LANES      = DEF_IN_LANES,
  localparam int unsigned BEATS         = calc_beats(MEM_BW, IO_DATA_WIDTH, IN_LANES),
  localparam int unsigned BCNT_W        = calc_bcnt_w(BEATS)
) (
  input  logic [MEM_BW-1:0]        word_in,
  input  logic [IO_DATA_WIDTH-1:0] lanes_in [IN_LANES],
  input  logic [BCNT_W-1:0]        beat_in,
  output logic [MEM_BW-1:0]        word_c
);

  // Constant slice positions per (beat, lane); beat_in selects which ones fire.
  always_comb begin
    word_c = word_in;
    for (int unsigned b = 0; b < BEATS; b++) begin
      for (int unsigned l = 0; l < IN_LANES; l++) begin
        if (beat_in == BCNT_W'(b)) begin
          word_c[MEM_BW-1-(b*IN_LANES+l)*IO_DATA_WIDTH -: IO_DATA_WIDTH] = lanes_in[l];
        end
      end
    end
  end

endmodule

// File: rtl/output_packer.sv
// Output packer: gathers IN_LANES-element beats from the PE array into MEM_BW
// words for the output/activation SRAM, element 0 at the MSB end.
// Ports:
//   clk, arst_n_in          clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready   beat input (in_last closes a word early)
//   out_data/out_count/out_valid/out_ready   packed word and valid element count
//   out_strobe              byte write enables, only with OUTPUT_PACKER_STROBE_EN
// Optional feature macro: OUTPUT_PACKER_STROBE_EN.
module output_packer
  import output_packer_pkg::*;
#(
  parameter  int unsigned IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter  int unsigned MEM_BW        = DEF_MEM_BW,
  parameter  int unsigned IN_LANES      = DEF_IN_LANES,
  localparam int unsigned ELEMS         = calc_elems(MEM_BW, IO_DATA_WIDTH),
  localparam int unsigned CNT_W         = calc_cnt_w(ELEMS)
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [IO_DATA_WIDTH-1:0] in_data [IN_LANES],
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [MEM_BW-1:0]        out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_valid,
`ifdef OUTPUT_PACKER_STROBE_EN
  output logic [MEM_BW/8-1:0]      out_strobe,
`endif
  input  logic                     out_ready
);

  localparam int unsigned BEATS  = calc_beats(MEM_BW, IO_DATA_WIDTH, IN_LANES);
  localparam int unsigned BCNT_W = calc_bcnt_w(BEATS);

  logic [BCNT_W-1:0] bcnt_q,      bcnt_d;
  logic [MEM_BW-1:0] asm_q,       asm_d;
  logic [MEM_BW-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_valid_q, out_valid_d;
  logic [MEM_BW-1:0] merged_c;
  logic              accept_c;
  logic              closing_c;

`ifdef OUTPUT_PACKER_STROBE_EN
  localparam int unsigned STRB_W = MEM_BW / 8;
  logic [STRB_W-1:0] strobe_q, strobe_d;
  int unsigned       nbytes_c;
`endif

  // The holding register frees up in the same cycle it is drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept_c  = in_valid && in_ready;
  assign closing_c = accept_c && (in_last || (bcnt_q == BCNT_W'(BEATS - 1)));

  packer_lane_insert #(
    .IO_DATA_WIDTH (IO_DATA_WIDTH),
    .MEM_BW        (MEM_BW),
    .IN_LANES      (IN_LANES)
  ) u_lane_insert (
    .word_in  (asm_q),
    .lanes_in (in_data),
    .beat_in  (bcnt_q),
    .word_c   (merged_c)
  );

  // Next-state: assembly, beat counter and output holding register.
  always_comb begin
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
`ifdef OUTPUT_PACKER_STROBE_EN
    strobe_d    = strobe_q;
    nbytes_c    = 0;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept_c) begin
      if (closing_c) begin
        // Assembly is cleared after each word, so unfilled positions are zero.
        out_data_d  = merged_c;
        out_count_d = CNT_W'((32'(bcnt_q) + 32'd1) * IN_LANES);
        out_valid_d = 1'b1;
        bcnt_d      = '0;
        asm_d       = '0;
`ifdef OUTPUT_PACKER_STROBE_EN
        // Bytes holding valid elements, counted down from the MSB byte.
        nbytes_c = (32'(out_count_d) * IO_DATA_WIDTH + 32'd7) / 32'd8;
        for (int unsigned i = 0; i < STRB_W; i++) begin
          strobe_d[i] = ((STRB_W - 1 - i) < nbytes_c);
        end
`endif
      end else begin
        asm_d  = merged_c;
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      bcnt_q      <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
`ifdef OUTPUT_PACKER_STROBE_EN
      strobe_q    <= '0;
`endif
    end else begin
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
`ifdef OUTPUT_PACKER_STROBE_EN
      strobe_q    <= strobe_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
`ifdef OUTPUT_PACKER_STROBE_EN
  assign out_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_output_packer.sv
// Scoreboard bench for output_packer at default parameters.
module tb_output_packer;
  import output_packer_pkg::*;

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   cnt;
    logic [15:0]  strb;
  } exp_t;

  logic         clk = 1'b0;
  logic         arst_n_in;
  elem_arr_t    in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] out_data;
  logic [4:0]   out_count;
  logic         out_valid;
  logic         out_ready;
`ifdef OUTPUT_PACKER_STROBE_EN
  logic [15:0]  out_strobe;
`endif

  output_packer dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
`ifdef OUTPUT_PACKER_STROBE_EN
    .out_strobe(out_strobe),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   hs_cyc[$];
  exp_t mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Word with element k = base+k for k < n, zero padding after.
  function automatic logic [127:0] mk(input int base, input int n);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[127-k*8 -: 8] = 8'(base + k);
    return w;
  endfunction

  task automatic push_exp(input logic [127:0] d, input logic [4:0] c, input logic [15:0] s);
    exp_t e;
    e.data = d; e.cnt = c; e.strb = s;
    exp_q.push_back(e);
  endtask

  // Monitor: a word is consumed at the next rising edge.
  always @(negedge clk) begin
    if (arst_n_in && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", out_data, mon_e.data);
        check("word_count", 128'(out_count), 128'(mon_e.cnt));
`ifdef OUTPUT_PACKER_STROBE_EN
        check("word_strobe", 128'(out_strobe), 128'(mon_e.strb));
`endif
      end
    end
  end

  // Drive one beat (elements base..base+3); returns cycles until accepted.
  task automatic send_beat(input int base, input logic last, output int waited);
    bit ok;
    for (int l = 0; l < 4; l++) in_data[l] = 8'(base + l);
    in_valid = 1'b1;
    in_last  = last;
    ok       = 1'b0;
    waited   = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=%0d required=accepted", waited);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    int t;
    arst_n_in = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int l = 0; l < 4; l++) in_data[l] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_count", 128'(out_count), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;

    // Full word 0x00..0x0F, one-cycle latency.
    push_exp(128'h000102030405060708090A0B0C0D0E0F, 5'd16, 16'hFFFF);
    for (int b = 0; b < 4; b++) begin
      send_beat(b * 4, 1'b0, w);
      if (b < 3) check("lat_no_early_valid", 128'(out_valid), 128'(0));
    end
    check("lat_valid_after_close", 128'(out_valid), 128'(1));
    idle(3);

    // Two back-to-back words at full rate.
    push_exp(mk(8'h10, 16), 5'd16, 16'hFFFF);
    push_exp(mk(8'h20, 16), 5'd16, 16'hFFFF);
    for (int b = 0; b < 8; b++) begin
      send_beat(8'h10 + b * 4, 1'b0, w);
      check("stream_in_ready", 128'(w), 128'(1));
    end
    idle(3);
    n = hs_cyc.size();
    if (n >= 2) check("stream_word_spacing", 128'(hs_cyc[n-1] - hs_cyc[n-2]), 128'(4));
    else check("stream_word_count", 128'(n), 128'(2));

    // Partial word closed by in_last on the second beat.
    push_exp(128'hA0A1A2A3A4A5A6A7_0000000000000000, 5'd8, 16'hFF00);
    send_beat(8'hA0, 1'b0, w);
    send_beat(8'hA4, 1'b1, w);
    idle(3);

    // Backpressure: word held, next beats refused.
    out_ready = 1'b0;
    push_exp(mk(8'h30, 16), 5'd16, 16'hFFFF);
    push_exp(mk(8'h40, 16), 5'd16, 16'hFFFF);
    for (int b = 0; b < 4; b++) send_beat(8'h30 + b * 4, 1'b0, w);
    for (int l = 0; l < 4; l++) in_data[l] = 8'(8'h40 + l);
    in_valid = 1'b1;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready_low", 128'(in_ready), 128'(0));
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_data_stable", out_data, mk(8'h30, 16));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    for (int b = 1; b < 4; b++) send_beat(8'h40 + b * 4, 1'b0, w);
    idle(3);

    // in_last on the final beat of a word: exactly one word.
    push_exp(mk(8'h50, 16), 5'd16, 16'hFFFF);
    for (int b = 0; b < 4; b++) send_beat(8'h50 + b * 4, (b == 3), w);
    idle(6);
    check("last_on_boundary_drained", 128'(exp_q.size()), 128'(0));

    // Reset mid-word discards the partial word.
    send_beat(8'h60, 1'b0, w);
    send_beat(8'h64, 1'b0, w);
    idle(1);
    arst_n_in = 1'b0;
    #2;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    push_exp(mk(8'h70, 16), 5'd16, 16'hFFFF);
    for (int b = 0; b < 4; b++) send_beat(8'h70 + b * 4, 1'b0, w);
    idle(2);

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
